// File: rtl/tlc_pkg.sv
// Shared types and default timing for the traffic_light_controller family of blocks.
// Phase codes are part of the external interface (phase output) and must not be renumbered.
package tlc_pkg;

  typedef enum logic [2:0] {
    G_NS = 3'd0,
    Y_NS = 3'd1,
    AR_A = 3'd2,
    G_EW = 3'd3,
    Y_EW = 3'd4,
    AR_B = 3'd5,
    WALK = 3'd6,
    AR_P = 3'd7
  } phase_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam int TLC_TW           = 6;
  localparam int TLC_MIN_GREEN    = 10;
  localparam int TLC_MAX_GREEN    = 30;
  localparam int TLC_YELLOW_TIME  = 5;
  localparam int TLC_ALL_RED_TIME = 2;
  localparam int TLC_WALK_TIME    = 8;

  function automatic phase_t green_of(input logic dir);
    return (dir == DIR_EW) ? G_EW : G_NS;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick counter for the current phase: synchronous clear, saturation at all-ones,
// and an expired flag meaning "this tick completes a phase of i_limit ticks".
module phase_timer #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_tick,
  input  logic          i_clear,
  input  logic [TW-1:0] i_limit,
  output logic [TW-1:0] o_count,
  output logic          o_expired
);

  localparam logic [TW-1:0] C_SAT = '1;

  logic [TW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick && (r_count != C_SAT)) begin
      r_count <= r_count + TW'(1);
    end
  end

  // Limits are at least 1, so limit-1 never wraps.
  assign o_expired = i_tick && (r_count >= (i_limit - TW'(1)));
  assign o_count   = r_count;

endmodule

// File: rtl/phase_request_arbiter.sv
// Right-of-way arbiter for a 4-way crossing: NS/EW vehicle greens, optional
// pedestrian phase (build with PED_PHASE_EN), and emergency pre-empt.
module phase_request_arbiter
  import tlc_pkg::*;
#(
  parameter int TW           = TLC_TW,
  parameter int MIN_GREEN    = TLC_MIN_GREEN,
  parameter int MAX_GREEN    = TLC_MAX_GREEN,
  parameter int YELLOW_TIME  = TLC_YELLOW_TIME,
  parameter int ALL_RED_TIME = TLC_ALL_RED_TIME,
  parameter int WALK_TIME    = TLC_WALK_TIME
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          ns_req,
  input  logic          ew_req,
  input  logic          ped_req,
  input  logic          emg_req,
  input  logic          emg_dir,
  output logic          ns_red,
  output logic          ns_yellow,
  output logic          ns_green,
  output logic          ew_red,
  output logic          ew_yellow,
  output logic          ew_green,
  output logic          walk,
  output logic          ped_ack,
  output logic [2:0]    phase,
  output logic [TW-1:0] timer
);

  localparam logic [TW-1:0] C_MIN_GREEN = TW'(MIN_GREEN);
  localparam logic [TW-1:0] C_MAX_LAST  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] C_YELLOW    = TW'(YELLOW_TIME);
  localparam logic [TW-1:0] C_ALL_RED   = TW'(ALL_RED_TIME);
  localparam logic [TW-1:0] C_WALK      = TW'(WALK_TIME);

  phase_t        r_state;
  phase_t        w_next;
  logic [TW-1:0] w_limit;
  logic [TW-1:0] w_timer;
  logic          w_expired;
  logic          w_max_expired;
  logic          w_change;
  logic          w_ped;
  logic          w_ns_demand;
  logic          w_ew_demand;

  phase_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_tick    (tick),
    .i_clear   (w_change),
    .i_limit   (w_limit),
    .o_count   (w_timer),
    .o_expired (w_expired)
  );

  assign w_change      = (w_next != r_state);
  assign w_max_expired = tick && (w_timer >= C_MAX_LAST);

`ifdef PED_PHASE_EN
  logic r_ped_pending;
  logic r_last_dir;

  // A press in the WALK entry cycle is a new call and must survive the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ped_pending <= 1'b0;
    end else if (ped_req) begin
      r_ped_pending <= 1'b1;
    end else if ((w_next == WALK) && (r_state != WALK)) begin
      r_ped_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_dir <= DIR_NS;
    end else if ((w_next == AR_A) && (r_state != AR_A)) begin
      r_last_dir <= DIR_NS;
    end else if ((w_next == AR_B) && (r_state != AR_B)) begin
      r_last_dir <= DIR_EW;
    end
  end

  assign w_ped = r_ped_pending;
`else
  logic w_unused_ped;
  assign w_unused_ped = ped_req;
  assign w_ped        = 1'b0;
`endif

  // Opposing demand seen from each green.
  assign w_ew_demand = ew_req | w_ped;
  assign w_ns_demand = ns_req | w_ped;

  always_comb begin
    w_limit = C_MIN_GREEN;
    case (r_state)
      G_NS, G_EW: w_limit = C_MIN_GREEN;
      Y_NS, Y_EW: w_limit = C_YELLOW;
      AR_A, AR_B: w_limit = C_ALL_RED;
      WALK:       w_limit = C_WALK;
      AR_P:       w_limit = C_ALL_RED;
      default:    w_limit = C_MIN_GREEN;
    endcase
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    if (tick) begin
      case (r_state)
        G_NS: begin
          // Pre-empt toward NS holds green; toward EW ends it at once.
          if (emg_req) begin
            if (emg_dir == DIR_EW) w_next = Y_NS;
          end else if (w_ew_demand && (w_expired || w_max_expired)) begin
            w_next = Y_NS;
          end
        end
        G_EW: begin
          if (emg_req) begin
            if (emg_dir == DIR_NS) w_next = Y_EW;
          end else if (w_ns_demand && (w_expired || w_max_expired)) begin
            w_next = Y_EW;
          end
        end
        Y_NS: if (w_expired) w_next = AR_A;
        Y_EW: if (w_expired) w_next = AR_B;
        AR_A: begin
          if (w_expired) begin
            if (emg_req)    w_next = green_of(emg_dir);
`ifdef PED_PHASE_EN
            else if (w_ped) w_next = WALK;
`endif
            else            w_next = G_EW;
          end
        end
        AR_B: begin
          if (w_expired) begin
            if (emg_req)    w_next = green_of(emg_dir);
`ifdef PED_PHASE_EN
            else if (w_ped) w_next = WALK;
`endif
            else            w_next = G_NS;
          end
        end
`ifdef PED_PHASE_EN
        WALK: if (w_expired || emg_req) w_next = AR_P;
        AR_P: begin
          if (w_expired) begin
            if (emg_req) w_next = green_of(emg_dir);
            else         w_next = green_of(~r_last_dir);
          end
        end
`endif
        default: w_next = G_NS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= G_NS;
    end else begin
      r_state <= w_next;
    end
  end

  // Moore lamp decode from the state register only.
  always_comb begin
    ns_green  = (r_state == G_NS);
    ns_yellow = (r_state == Y_NS);
    ns_red    = !(ns_green || ns_yellow);
    ew_green  = (r_state == G_EW);
    ew_yellow = (r_state == Y_EW);
    ew_red    = !(ew_green || ew_yellow);
  end

`ifdef PED_PHASE_EN
  assign walk    = (r_state == WALK);
  assign ped_ack = r_ped_pending;
`else
  assign walk    = 1'b0;
  assign ped_ack = 1'b0;
`endif

  assign phase = r_state;
  assign timer = w_timer;

endmodule

// File: doc/phase_request_arbiter.md
Name: phase_request_arbiter

Overview:
- Demand-driven right-of-way arbiter for a 4-way intersection. It shares the crossing between the NS and EW vehicle approaches, a pedestrian call and an emergency pre-empt.
- Grants green phases under min/max green limits, with round-robin fairness between the two approaches.
- Yellow and all-red safety intervals are never shortened.
- Drives the six lamp outputs plus walk signal. Sits between the sensor/button input conditioning and the lamp drivers.

Parameters:
- TW, 6, timer width in bits; every *_TIME must be between 1 and 2^TW-1.
- MIN_GREEN, 10, minimum green in ticks before a demand-driven change.
- MAX_GREEN, 30, green length after which an opposing demand forces a change.
- YELLOW_TIME, 5, yellow length in ticks.
- ALL_RED_TIME, 2, all-red clearance in ticks.
- WALK_TIME, 8, pedestrian walk length in ticks.

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset, asynchronous, active-high.
- tick, in, 1, one-cycle timing strobe; all timing counts tick cycles only.
- ns_req, in, 1, NS vehicle detector (level).
- ew_req, in, 1, EW vehicle detector (level).
- ped_req, in, 1, pedestrian button (pulse or level).
- emg_req, in, 1, emergency pre-empt (level).
- emg_dir, in, 1, pre-empt direction; 0 = NS, 1 = EW.
- ns_red / ns_yellow / ns_green, out, 1 each, NS lamps.
- ew_red / ew_yellow / ew_green, out, 1 each, EW lamps.
- walk, out, 1, pedestrian walk lamp.
- ped_ack, out, 1, pedestrian call pending (button lamp).
- phase, out, 3, current state code.
- timer, out, TW, ticks elapsed in current state.

Behaviour:
- States and codes: G_NS=0, Y_NS=1, AR_A=2, G_EW=3, Y_EW=4, AR_B=5, WALK=6, AR_P=7.
- Reset: state G_NS, timer=0, ped_pending=0, last_dir=NS.
  - Outputs after reset: ns_green=1, ew_red=1, all other lamps 0, walk=0, ped_ack=0, phase=0.
- Outputs are Moore (decoded from the state register only). Exactly one lamp per direction is lit.
  - WALK and AR_P: both directions red.
  - walk=1 only in WALK.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise +1 on tick, saturating at 2^TW-1.
  - State transitions are evaluated only in cycles where tick=1. The new state is visible the cycle after that tick.
  - "Expired(T)" means tick && timer >= T-1.
- Opposing demand:
  - In G_NS: demand = ew_req | ped_pending.
  - In G_EW: demand = ns_req | ped_pending.
- G_NS -> Y_NS on tick when any of:
  - Emergency pre-empt with emg_dir=EW (ignores MIN_GREEN).
  - Expired(MIN_GREEN) and opposing demand.
- With no opposing demand, green rests indefinitely and the timer saturates.
- G_EW is symmetric to G_NS.
- Emergency hold: while emg_req=1 and current green direction equals emg_dir, the green holds regardless of timer or demands.
- Yellow and all-red:
  - Y_NS -> AR_A on Expired(YELLOW_TIME). Y_EW -> AR_B likewise.
  - AR_A, on Expired(ALL_RED_TIME):
    - -> G of emg_dir if emg_req=1.
    - Else -> WALK if ped_pending.
    - Else -> G_EW.
  - AR_B is the mirror of AR_A, defaulting to G_NS.
  - last_dir is recorded on entering AR_A (NS) or AR_B (EW).
- Pedestrian phase:
  - WALK -> AR_P on Expired(WALK_TIME), or on the first tick with emg_req=1 (walk truncated).
  - AR_P -> on Expired(ALL_RED_TIME): G of emg_dir if emg_req=1, else green opposite to last_dir.
- ped_pending:
  - Set on ped_req=1; cleared on entry to WALK.
  - If ped_req=1 in the entry cycle, set wins: the call stays pending for the next cycle.
  - ped_ack = ped_pending.
  - Emergency suppresses WALK entry; the call remains pending.
- Simultaneous ns_req and ew_req: round robin is inherent because green always alternates. Neither direction can hold the crossing beyond MAX_GREEN while the other demands.
- Reset asserted mid-operation: immediate return to reset values, any state.
- Illegal phase codes cannot occur.

Optional Feature:
- Macro: PED_PHASE_EN.
- Defined: pedestrian logic as above.
- Undefined:
  - ped_req ignored; ped_pending, walk and ped_ack tied 0.
  - WALK and AR_P are unreachable and removed.
  - AR_A and AR_B go directly to the opposite green (or the emg_dir green).

Decomposition:
- Package tlc_pkg:
  - State codes (3-bit typedef).
  - Direction constants NS=0 / EW=1.
  - Default timing constants shared with traffic_light_controller-family blocks.
- One sub-module, phase_timer:
  - TW-bit tick counter with synchronous clear, saturation, and an expired(T) compare output.

Test Plan:
- Reset, ew_req=1, ns_req=0, tick every cycle -> G_NS for 10 ticks, Y_NS 5, AR_A 2, then G_EW with timer=0 at tick 17.
- No requests for 100 ticks -> stays G_NS, timer saturates at 63, no yellow ever.
- ns_req=ew_req=1 constant -> alternates each MIN_GREEN (10/5/2 cycle), no direction skipped.
- ped_req pulse during G_NS at timer=3, ew_req=0 -> Y_NS at tick 10, AR_A, WALK 8 ticks (walk=1, all red), AR_P 2 ticks, G_EW.
  - ped_ack stays 1 from the pulse until WALK entry.
- emg_req=1, emg_dir=EW at G_NS timer=2 -> Y_NS next tick (min green ignored), full 5 yellow + 2 all-red, G_EW held while emg_req=1.
  - With ped_pending=1, WALK is skipped and ped_ack stays 1.
- Reset asserted during Y_EW timer=3 -> same cycle: ns_green=1, ew_red=1, timer=0, ped_ack=0.
- Build without PED_PHASE_EN -> ped_req pulses have no effect and walk=0 throughout.
